// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared state encodings, opcodes and ALU op codes for the multicycle controller
package riscv_ctrl_pkg;
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_e;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam int WAIT_W = 8;
  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_LD) || (op == OP_SD) || (op == OP_BEQ);
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles and flags the cycle the count reaches TIMEOUT
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);
  import riscv_ctrl_pkg::*;
  logic [WAIT_W-1:0] r_count;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_count <= '0;
    else if (clear) r_count <= '0;
    else if (tick) r_count <= r_count + WAIT_W'(1);
  end
  // a ready strobe suppresses tick, so completion always beats the timeout
  assign expired = tick && !clear && (r_count == WAIT_W'(TIMEOUT - 1));
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for R-type, LD, SD and BEQ
// with a memory-wait timeout that traps until reset.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      instruction,
  input  logic             aluZero,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             irWrite,
  output logic             immEnable,
  output logic             regWrite,
  output logic             memReq,
  output logic             memWrite,
  output logic             aluSrc,
  output logic             memToReg,
  output logic [1:0]       aluOp,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);
  state_e           r_state;
  logic [6:0]       r_opcode;
  logic             r_run;
  logic [CNT_W-1:0] r_retired;
  logic             w_mem_req, w_done, w_tick, w_expired, w_retire;
  logic             w_is_r, w_is_ld, w_is_sd, w_is_beq, w_exec;
  logic             w_unused_ir;
  assign w_unused_ir = ^instruction[31:7];
  assign w_is_r   = r_opcode == OP_RTYPE;
  assign w_is_ld  = r_opcode == OP_LD;
  assign w_is_sd  = r_opcode == OP_SD;
  assign w_is_beq = r_opcode == OP_BEQ;
  assign w_exec   = r_state == S_EXECUTE;
  // r_run holds memReq low until the first edge after reset release
  assign w_mem_req = r_run && (r_state == S_FETCH || r_state == S_MEM);
  assign w_done    = w_mem_req && memReady;
  assign w_tick    = w_mem_req && !memReady;
  assign w_retire  = (w_exec && w_is_beq) || (r_state == S_MEM && w_done && w_is_sd) ||
                     (r_state == S_WRITEBACK);
  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (!w_tick),
    .tick   (w_tick),
    .expired(w_expired)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_opcode  <= '0;
      r_run     <= 1'b0;
      r_retired <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
      case (r_state)
        S_FETCH:     r_state <= w_done ? S_DECODE : (w_expired ? S_TRAP : S_FETCH);
        S_DECODE: begin
          r_opcode <= instruction[6:0];
          r_state  <= is_supported(instruction[6:0]) ? S_EXECUTE : S_TRAP;
        end
        S_EXECUTE:   r_state <= w_is_r ? S_WRITEBACK : (w_is_beq ? S_FETCH : S_MEM);
        S_MEM:       r_state <= w_done ? (w_is_ld ? S_WRITEBACK : S_FETCH) :
                                (w_expired ? S_TRAP : S_MEM);
        S_WRITEBACK: r_state <= S_FETCH;
        default:     r_state <= S_TRAP;
      endcase
    end
  end
  assign memReq    = w_mem_req;
  assign memWrite  = w_mem_req && r_state == S_MEM && w_is_sd;
  assign irWrite   = r_state == S_FETCH && w_done;
  assign pcWrite   = (r_state == S_FETCH && w_done) || (w_exec && w_is_beq && aluZero);
  assign immEnable = r_state == S_DECODE;
  assign regWrite  = r_state == S_WRITEBACK;
  assign memToReg  = r_state == S_WRITEBACK && w_is_ld;
  assign aluSrc    = w_exec && (w_is_ld || w_is_sd);
  assign aluOp     = !w_exec ? ALU_ADD : (w_is_r ? ALU_FUNCT : (w_is_beq ? ALU_SUB : ALU_ADD));
  assign trap      = r_state == S_TRAP;
  assign state     = r_state;
  assign retired   = r_retired;
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16, giving the max cycles to wait for memReady before trapping (legal range 2..255).
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of the retired-instruction counter.
REQ-003 The block SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port instruction, input, 32: the current IR contents; opcode is instruction[6:0], funct3 is [14:12], funct7 is [31:25].
REQ-006 The block SHALL have port aluZero, input, 1: ALU zero flag, valid in EXECUTE.
REQ-007 The block SHALL have port memReady, input, 1: memory completion strobe for the current memReq.
REQ-008 The block SHALL have outputs pcWrite, irWrite, immEnable, regWrite, memReq, memWrite, aluSrc, memToReg, each 1 bit: datapath strobes and selects.
REQ-009 The block SHALL have output aluOp, 2 bits: 00 add, 01 subtract, 10 decode funct3/funct7.
REQ-010 The block SHALL have outputs trap (1 bit), state (3 bits) and retired (CNT_W bits).

Function
REQ-011 The block SHALL use states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5, with one state register.
REQ-012 In FETCH, memReq=1 and memWrite=0; on memReady=1 the block SHALL assert irWrite and pcWrite for that cycle and move to DECODE.
REQ-013 In DECODE, immEnable=1 for one cycle; R-type (0110011), LD (0000011), SD (0100011) and BEQ (1100011) SHALL go to EXECUTE; any other opcode SHALL go to TRAP.
REQ-014 In EXECUTE, R-type SHALL drive aluSrc=0 and aluOp=10, then go to WRITEBACK.
REQ-015 In EXECUTE, LD and SD SHALL drive aluSrc=1 and aluOp=00, then go to MEM.
REQ-016 In EXECUTE, BEQ SHALL drive aluSrc=0 and aluOp=01, assert pcWrite iff aluZero=1, increment retired, and return to FETCH; BEQ latency is 3 cycles plus fetch wait.
REQ-017 In MEM, memReq=1, with memWrite=1 for SD and 0 for LD; on memReady, LD SHALL go to WRITEBACK, and SD SHALL increment retired and go to FETCH.
REQ-018 In WRITEBACK, regWrite=1 for exactly one cycle, with memToReg=1 for LD and 0 for R-type; the block SHALL then increment retired and go to FETCH.
REQ-019 memReq SHALL stay high from state entry until the cycle memReady is sampled high inclusive, and SHALL be low the following cycle.
REQ-020 A memReady seen while memReq=0 SHALL be ignored.
REQ-021 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle memReady=0.
REQ-022 If the wait counter reaches MEM_TIMEOUT, the block SHALL go to TRAP.
REQ-023 If memReady arrives in the same cycle the wait counter reaches MEM_TIMEOUT, completion SHALL win.
REQ-024 TRAP SHALL be absorbing: trap=1, all strobes 0, exit only via reset.
REQ-025 retired SHALL wrap modulo 2^CNT_W with no flag.
REQ-026 All outputs SHALL be Moore-decoded from registered state and the registered opcode, except pcWrite in EXECUTE (aluZero) and irWrite/pcWrite in FETCH (memReady), which are combinational.
REQ-027 The opcode SHALL be latched in DECODE and held through WRITEBACK, independent of later IR changes.

Reset
REQ-028 On reset_n=0, the block SHALL asynchronously enter FETCH, clear the wait counter, retired and trap, and drive all strobes to 0.
REQ-029 memReq SHALL rise on the first clock edge after reset_n deasserts.
REQ-030 Reset in any state, including mid-handshake, SHALL abort the instruction with no regWrite or memWrite issued afterward.

Structure
REQ-031 State encodings, opcode constants and aluOp codes SHALL live in a shared package riscv_ctrl_pkg, also used by ImmediateGenerator consumers.
REQ-032 The wait/timeout counter SHALL be a sub-module mem_wait_timer with ports clock, reset_n, clear, tick and expired.

Verification
REQ-033 Bench: R-type add (0x003100B3), memReady 1 cycle after request -> states 0,1,2,4,0; regWrite high 1 cycle; retired=1.
REQ-034 Bench: LD (0x00013083), memReady delayed 3 cycles in MEM -> memReq high 4 cycles; memToReg=1 in WRITEBACK.
REQ-035 Bench: BEQ with aluZero=1 vs 0 -> pcWrite pulses in EXECUTE only in the aluZero=1 case; retired increments in both.
REQ-036 Bench: SD with memReady never asserted -> TRAP after exactly 16 waiting cycles; trap=1 and stays high until reset.
REQ-037 Bench: opcode 0x7F -> TRAP from DECODE; no regWrite or memReq asserted.
REQ-038 Bench: reset_n low mid-MEM for an SD -> state=0 immediately and memWrite=0; with retired preset near 2^CNT_W-1, retired wraps to 0.
